uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between NREQ byte-stream requesters, e.g. the echo unit and the response-string generator.
- Each requester owns the transmitter for a whole packet: from its first accepted byte through the byte flagged last.
- Ownership is granted round-robin.
- An inactivity timeout reclaims the transmitter from a requester that stalls mid-packet.
- Sits between the requesters and uart_tx; replaces per-state tx_start/tx_data muxing in the top level.

---
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between NREQ byte-stream requesters. A requester owns
//   the transmitter for a whole packet, from its first accepted byte through
//   the byte flagged last. Ownership is granted round-robin. An inactivity
//   timeout reclaims the transmitter from an owner that stalls mid-packet.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   req_valid    [NREQ]   requester i presents a byte
//   req_data     [8*NREQ] byte of requester i in bits [8i+7:8i]
//   req_last     [NREQ]   byte of requester i ends its packet
//   req_ready    [NREQ]   byte of requester i accepted this cycle (comb)
//   grant        [NREQ]   one-hot registered ownership
//   tx_start     one-cycle start pulse to uart_tx (registered)
//   tx_data      byte to uart_tx, held until the next load
//   tx_busy      uart_tx busy, rises the cycle after tx_start
//   arb_busy     high whenever the arbiter is not idle
//   timeout_evt  one-cycle pulse when an owner is force-released
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 12000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic              timeout_evt
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [OW-1:0] OWNER_RST = OW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic            tx_start_n;
  logic [7:0]      tx_data_n;
  logic            timeout_n;
  logic [OW-1:0]   owner, owner_n;
  logic [OW-1:0]   last_owner, last_owner_n;
  logic [CW-1:0]   idle_cnt, idle_cnt_n;
  logic            last_flag, last_flag_n;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [OW-1:0]   cand;
  logic            accept;
  logic [7:0]      owner_byte;

  // Round-robin scan starting one past the previous owner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(last_owner) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_byte = req_data[{owner, 3'b000} +: 8];
  assign accept     = (state == S_LOAD) && req_valid[owner] && !tx_busy;
  assign arb_busy   = (state != S_IDLE);

  // Only the owner can ever see ready, and only while loading.
  always_comb begin
    req_ready = '0;
    if (state == S_LOAD) req_ready[owner] = req_valid[owner] && !tx_busy;
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    tx_start_n   = tx_start;
    tx_data_n    = tx_data;
    timeout_n    = 1'b0;
    owner_n      = owner;
    last_owner_n = last_owner;
    idle_cnt_n   = idle_cnt;
    last_flag_n  = last_flag;
    case (state)
      S_IDLE: begin
        if (win_found && !tx_busy) begin
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          owner_n          = win_idx;
          idle_cnt_n       = '0;
          state_n          = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          tx_data_n   = owner_byte;
          last_flag_n = req_last[owner];
          tx_start_n  = 1'b1;
          idle_cnt_n  = '0;
          state_n     = S_START;
        end else if ((TIMEOUT != 0) && (idle_cnt == CNT_LAST)) begin
          grant_n      = '0;
          last_owner_n = owner;
          timeout_n    = 1'b1;
          state_n      = S_IDLE;
        end else if (idle_cnt != '1) begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end
      S_START: begin
        tx_start_n = 1'b0;
        state_n    = S_GUARD;
      end
      // uart_tx raises busy one cycle after start; skip that blind cycle.
      S_GUARD: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (last_flag) begin
            grant_n      = '0;
            last_owner_n = owner;
            state_n      = S_IDLE;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      default: begin
        grant_n    = '0;
        tx_start_n = 1'b0;
        state_n    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_evt <= 1'b0;
      owner       <= '0;
      last_owner  <= OWNER_RST;
      idle_cnt    <= '0;
      last_flag   <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      timeout_evt <= timeout_n;
      owner       <= owner_n;
      last_owner  <= last_owner_n;
      idle_cnt    <= idle_cnt_n;
      last_flag   <= last_flag_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized packet
// traffic, checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              arb_busy;
  logic              timeout_evt;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy from the cycle after tx_start, unaffected by rst.
  int busy_cnt  = 0;
  int busy_len  = 10;
  bit busy_rand = 1'b0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_rand ? int'($urandom_range(12, 1)) : busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic [7:0]      cap_data[$];
  logic [NREQ-1:0] cap_grant[$];
  int              tmo_seen = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      cap_data.push_back(tx_data);
      cap_grant.push_back(grant);
    end
    if (timeout_evt) tmo_seen <= tmo_seen + 1;
  end

  logic [7:0] q_data[NREQ][$];
  bit         q_last[NREQ][$];
  int         exp_req[$];
  logic [7:0] exp_data[$];
  int         mdl_last = NREQ - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic add_pkt(input int r, input int n, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      q_data[r].push_back(rnd ? 8'($urandom) : base + 8'(i));
      q_last[r].push_back(i == n - 1);
    end
  endtask

  // Packet-level model: whoever is pending next after the last owner sends
  // its whole packet; every requester with queued bytes is always pending.
  task automatic build_expected();
    int  pos[NREQ];
    int  r, c;
    bit  found;
    foreach (pos[i]) pos[i] = 0;
    r = 0;
    forever begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (mdl_last + k) % NREQ;
        if (!found && pos[c] < q_data[c].size()) begin
          found = 1'b1;
          r = c;
        end
      end
      if (!found) break;
      do begin
        exp_req.push_back(r);
        exp_data.push_back(q_data[r][pos[r]]);
        pos[r]++;
      end while (pos[r] < q_data[r].size() && !q_last[r][pos[r]-1]);
      mdl_last = r;
    end
  endtask

  task automatic run_req(input int r, input int max_gap);
    int waited, g;
    bit first;
    first = 1'b1;
    while (q_data[r].size() != 0) begin
      if (!first && max_gap > 0) begin
        g = $urandom_range(max_gap, 0);
        if (g > 0) begin
          req_valid[r] = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      req_valid[r]        = 1'b1;
      req_data[8*r +: 8]  = q_data[r][0];
      req_last[r]         = q_last[r][0];
      #1;
      waited = 0;
      while (!req_ready[r] && waited < 3000) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!req_ready[r]) begin
        chk($sformatf("accept_wait_req%0d", r), 32'(req_ready[r]), 1);
        q_data[r].delete();
        q_last[r].delete();
        break;
      end
      @(negedge clk);
      first = q_last[r][0];
      void'(q_data[r].pop_front());
      void'(q_last[r].pop_front());
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_cap(input int n, input string tag);
    int k = 0;
    while (cap_data.size() < n && k < 400) begin tick(); k++; end
    chk({tag, "_start_seen"}, 32'(cap_data.size() >= n), 1);
  endtask

  task automatic wait_ready(input int r, input string tag);
    int k = 0;
    while (!req_ready[r] && k < 200) begin tick(); k++; end
    chk({tag, "_ready"}, 32'(req_ready[r]), 1);
  endtask

  // Returns at the first sampled cycle with tx_busy low after it was high.
  task automatic wait_frame_end(input string tag);
    int k = 0;
    bit rose = 1'b0;
    while (!tx_busy && k < 50) begin tick(); k++; end
    rose = tx_busy;
    while (tx_busy && k < 200) begin tick(); k++; end
    chk({tag, "_busy_rose"}, 32'(rose), 1);
    chk({tag, "_busy_fell"}, 32'(tx_busy), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((arb_busy || tx_busy || req_valid != '0) && n < 3000) begin tick(); n++; end
    chk({tag, "_quiesce"}, {30'd0, arb_busy, tx_busy}, 0);
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_count"}, 32'(cap_data.size()), 32'(exp_data.size()));
    n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(exp_data[i]));
      chk($sformatf("%s_grant%0d", tag, i), 32'(cap_grant[i]), 32'(1) << exp_req[i]);
    end
    cap_data.delete(); cap_grant.delete();
    exp_data.delete(); exp_req.delete();
  endtask

  task automatic run_phase(input string tag, input int max_gap);
    build_expected();
    fork
      run_req(0, max_gap);
      run_req(1, max_gap);
      run_req(2, max_gap);
    join
    wait_idle(tag);
    check_stream(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    mdl_last = NREQ - 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_timeout_evt", 32'(timeout_evt), 0);
    chk("rst_arb_busy", 32'(arb_busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    tick();

    // Single two-byte packet from requester 0.
    busy_len = 10;
    add_pkt(0, 2, 8'h48, 1'b0);
    build_expected();
    fork
      run_req(0, 0);
      begin
        wait_cap(2, "single");
        wait_frame_end("single");
        chk("single_grant_wait", 32'(grant), 32'b001);
        chk("single_busy_wait", 32'(arb_busy), 1);
        tick();
        chk("single_grant_end", 32'(grant), 0);
        chk("single_arb_end", 32'(arb_busy), 0);
      end
    join
    wait_idle("single");
    check_stream("single");

    // Contention and round-robin rotation.
    do_reset();
    add_pkt(0, 2, 8'hA0, 1'b0);
    add_pkt(1, 3, 8'hB0, 1'b0);
    run_phase("contend", 0);
    add_pkt(0, 1, 8'hC0, 1'b0);
    run_phase("solo", 0);
    add_pkt(0, 1, 8'hD0, 1'b0);
    add_pkt(1, 1, 8'hE0, 1'b0);
    run_phase("rr_pair", 0);
    add_pkt(0, 1, 8'h10, 1'b0);
    add_pkt(1, 2, 8'h20, 1'b0);
    add_pkt(2, 1, 8'h30, 1'b0);
    run_phase("rr_three", 0);

    // Packet lock: requester 1 arrives while requester 0 is mid-packet.
    add_pkt(0, 4, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) begin exp_req.push_back(0); exp_data.push_back(8'h40 + 8'(i)); end
    for (int i = 0; i < 2; i++) begin exp_req.push_back(1); exp_data.push_back(8'h70 + 8'(i)); end
    fork
      run_req(0, 0);
      begin
        wait_cap(2, "lock_join");
        add_pkt(1, 2, 8'h70, 1'b0);
        run_req(1, 0);
      end
      begin
        int k;
        wait_cap(2, "lock_watch");
        tick();
        k = 0;
        while (cap_data.size() < 4 && k < 200) begin
          chk("lock_ready1", 32'(req_ready[1]), 0);
          chk("lock_grant", 32'(grant), 32'b001);
          tick();
          k++;
        end
      end
    join
    wait_idle("lock");
    check_stream("lock");
    mdl_last = 1;

    // Timeout: owner drops valid mid-packet, requester 1 is waiting.
    do_reset();
    busy_len = 4;
    req_data[7:0] = 8'h11; req_last[0] = 1'b0; req_valid[0] = 1'b1;
    wait_ready(0, "tmo_first");
    tick();
    req_valid[0] = 1'b0;
    req_data[15:8] = 8'h22; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    wait_frame_end("tmo_frame");
    repeat (20) tick();
    chk("tmo_not_yet", 32'(timeout_evt), 0);
    chk("tmo_grant_held", 32'(grant), 32'b001);
    tick();
    chk("tmo_pulse", 32'(timeout_evt), 1);
    chk("tmo_grant_drop", 32'(grant), 0);
    chk("tmo_arb_idle", 32'(arb_busy), 0);
    tick();
    chk("tmo_pulse_end", 32'(timeout_evt), 0);
    chk("tmo_regrant", 32'(grant), 32'b010);
    wait_ready(1, "tmo_second");
    tick();
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    wait_idle("tmo");
    exp_req.push_back(0); exp_data.push_back(8'h11);
    exp_req.push_back(1); exp_data.push_back(8'h22);
    check_stream("tmo");
    mdl_last = 1;

    // Reset while waiting on an in-flight frame.
    busy_len = 30;
    req_data[7:0] = 8'h5A; req_last[0] = 1'b0; req_valid[0] = 1'b1;
    wait_cap(1, "rstmid");
    tick(); tick();
    req_data[7:0] = 8'h5B; req_last[0] = 1'b1;
    chk("rstmid_busy_before", 32'(arb_busy), 1);
    chk("rstmid_grant_before", 32'(grant), 32'b001);
    rst = 1'b1;
    tick();
    chk("rstmid_grant", 32'(grant), 0);
    chk("rstmid_tx_start", 32'(tx_start), 0);
    chk("rstmid_arb", 32'(arb_busy), 0);
    rst = 1'b0;
    begin
      int k = 0;
      while (tx_busy && k < 100) begin
        chk("rstmid_no_grant", 32'(grant), 0);
        tick();
        k++;
      end
    end
    chk("rstmid_grant_at_fall", 32'(grant), 0);
    tick();
    chk("rstmid_regrant", 32'(grant), 32'b001);
    wait_ready(0, "rstmid");
    tick();
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    wait_idle("rstmid");
    exp_req.push_back(0); exp_data.push_back(8'h5A);
    exp_req.push_back(0); exp_data.push_back(8'h5B);
    check_stream("rstmid");
    mdl_last = 0;

    // Back-to-back timing after busy falls.
    busy_len = 6;
    add_pkt(0, 3, 8'h31, 1'b0);
    build_expected();
    fork
      run_req(0, 0);
      begin
        wait_cap(1, "b2b");
        wait_frame_end("b2b");
        chk("b2b_n_ready", 32'(req_ready[0]), 0);
        tick();
        chk("b2b_n1_ready", 32'(req_ready[0]), 1);
        chk("b2b_n1_start", 32'(tx_start), 0);
        tick();
        chk("b2b_n2_start", 32'(tx_start), 1);
        chk("b2b_n2_data", 32'(tx_data), 32'h32);
        chk("b2b_n2_ready", 32'(req_ready[0]), 0);
        tick();
        chk("b2b_n3_start", 32'(tx_start), 0);
        chk("b2b_n3_data_hold", 32'(tx_data), 32'h32);
      end
    join
    wait_idle("b2b");
    check_stream("b2b");

    // Randomized packets, random in-packet gaps and frame lengths.
    do_reset();
    busy_rand = 1'b1;
    for (int rnd = 0; rnd < 5; rnd++) begin
      for (int r = 0; r < NREQ; r++) begin
        int npk;
        npk = $urandom_range(2, 0);
        for (int p = 0; p < npk; p++) add_pkt(r, int'($urandom_range(4, 1)), 8'h00, 1'b1);
      end
      run_phase($sformatf("rand%0d", rnd), 4);
    end
    busy_rand = 1'b0;

    chk("timeout_pulses", 32'(tmo_seen), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
